// File: rtl/logic_pipe_pkg.sv
// Shared constants and types for the pipelined logic unit.
package logic_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NAND = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  // Buffer occupancy: main register empty, main full, main + skid full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/logic_pipe_core.sv
// Combinational two-operand logic unit with zero/negative flags.
module logic_core
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zr_o,
  output logic             ng_o
);

  // Op decode; the two unary ops ignore b.
  always_comb begin
    res_o = a_i;
    case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NAND: res_o = ~(a_i & b_i);
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_XNOR: res_o = ~(a_i ^ b_i);
      OP_NOT:  res_o = ~a_i;
      default: res_o = a_i;
    endcase
  end

  assign zr_o = ~|res_o;
  assign ng_o = res_o[WIDTH-1];

endmodule

// File: rtl/logic_pipe.sv
// Pipelined logic unit: result computed at the input, stored in a 2-entry
// elastic buffer (main + skid) so in_ready can be registered without losing
// throughput under backpressure.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  // Entry layout: {result, zr, ng}. Reset value describes a zero result.
  localparam int EW = WIDTH + 2;
  localparam logic [EW-1:0] ENT_RST = {{WIDTH{1'b0}}, 1'b1, 1'b0};

  logic [WIDTH-1:0] core_res;
  logic             core_zr, core_ng;
  logic [EW-1:0]    core_ent;
  logic [EW-1:0]    main_q, main_d, skid_q, skid_d;
  state_e           state_q, state_d;
  logic             in_ready_q;
  logic             push, pop;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (a),
    .b_i   (b),
    .op_i  (op),
    .res_o (core_res),
    .zr_o  (core_zr),
    .ng_o  (core_ng)
  );

  assign core_ent  = {core_res, core_zr, core_ng};
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // Occupancy FSM; registers only load on an accepted push so X on idle
  // operands never reaches state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = core_ent;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = core_ent;
        end else if (push) begin
          skid_d  = core_ent;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and storage; in_ready is registered from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= ENT_RST;
      skid_q     <= ENT_RST;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign out = main_q[EW-1:2];
  assign zr  = main_q[1];
  assign ng  = main_q[0];

endmodule

// File: tb/tb_logic_pipe.sv
// Directed + random self-checking bench for logic_pipe (WIDTH=16).
module tb_logic_pipe;
  import logic_pipe_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, out;
  logic [2:0]  op;
  logic        zr, ng;

  int checks   = 0;
  int failures = 0;

  logic [17:0] q[$];

  logic_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
  endtask

  // One transaction, checked the cycle after acceptance, then idle.
  task automatic one_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] e, input logic ez, input logic en);
    drive(1'b1, o, x, y);
    tick();
    in_valid = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(e));
    chk({tag, "_zr"},  32'(zr), 32'(ez));
    chk({tag, "_ng"},  32'(ng), 32'(en));
    tick();
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [17:0] mdl(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = ~x;
      default: r = x;
    endcase
    return {r, (r == 16'h0000), r[15]};
  endfunction

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'bxxx, 16'hxxxx, 16'hxxxx);
    #12;
    chk("rst_vld",   32'(out_valid), 32'd0);
    chk("rst_out",   32'(out), 32'h0);
    chk("rst_zr",    32'(zr), 32'd1);
    chk("rst_ng",    32'(ng), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    #5 rst_n = 1'b1;
    tick();
    chk("rst_ready_rise", 32'(in_ready), 32'd1);

    // Individual ops
    one_op("and0", OP_AND,  16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b0);
    one_op("xor",  OP_XOR,  16'h3CC3, 16'h0FF0, 16'h3333, 1'b0, 1'b0);
    one_op("and1", OP_AND,  16'h1234, 16'h9876, 16'h1034, 1'b0, 1'b0);
    one_op("nand", OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    one_op("not",  OP_NOT,  16'h0000, 16'hxxxx, 16'hFFFF, 1'b0, 1'b1);
    one_op("pass", OP_PASS, 16'h8001, 16'hxxxx, 16'h8001, 1'b0, 1'b1);
    one_op("nor",  OP_NOR,  16'h00FF, 16'h0F00, 16'hF000, 1'b0, 1'b1);

    // Back-to-back streaming with simultaneous push+pop: no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, OP_OR, 16'(i), 16'(i << 8));
      tick();
      chk("b2b_ready", 32'(in_ready), 32'd1);
      chk("b2b_vld",   32'(out_valid), 32'd1);
      chk("b2b_out",   32'(out), 32'((i << 8) | i));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: fill main + skid, third offer held
    out_ready = 1'b0;
    drive(1'b1, OP_OR, 16'h00F0, 16'h0F00);
    tick();
    chk("bp1_out",   32'(out), 32'h0FF0);
    chk("bp1_ready", 32'(in_ready), 32'd1);
    drive(1'b1, OP_XNOR, 16'h0000, 16'h0000);
    tick();
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_out",   32'(out), 32'h0FF0);
    drive(1'b1, OP_AND, 16'hFFFF, 16'h0001);
    tick();
    chk("bp3_ready", 32'(in_ready), 32'd0);
    chk("bp3_out",   32'(out), 32'h0FF0);
    tick();
    chk("bp4_out",   32'(out), 32'h0FF0);
    chk("bp4_vld",   32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_rel0", 32'(out), 32'h0FF0);
    tick();
    chk("bp_rel1",    32'(out), 32'hFFFF);
    chk("bp_rel1_ng", 32'(ng), 32'd1);
    chk("bp_rel1_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_rel2", 32'(out), 32'h0001);
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Async reset while full
    out_ready = 1'b0;
    drive(1'b1, OP_PASS, 16'h1111, 16'h0);
    tick();
    drive(1'b1, OP_PASS, 16'h2222, 16'h0);
    tick();
    in_valid = 1'b0;
    chk("two_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld",   32'(out_valid), 32'd0);
    chk("arst_out",   32'(out), 32'h0);
    chk("arst_zr",    32'(zr), 32'd1);
    chk("arst_ready", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("arst_ready_rise", 32'(in_ready), 32'd1);
    chk("arst_vld2",       32'(out_valid), 32'd0);
    out_ready = 1'b1;
    one_op("post_rst", OP_OR, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);

    // Random traffic against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic push, pop;
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid) drive(1'b1, 3'($urandom), 16'($urandom), 16'($urandom));
      else          drive(1'b0, 3'bxxx, 16'hxxxx, 16'hxxxx);
      #1;
      chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd_vld",   32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd_ent", 32'({out, zr, ng}), 32'(q[0]));
      push = in_valid && (q.size() < 2);
      pop  = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(mdl(op, a, b));
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (q.size() != 0) chk("drain_ent", 32'({out, zr, ng}), 32'(q[0]));
      if (q.size() != 0) void'(q.pop_front());
      tick();
    end
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
